image_out_streamer: RTL and testbench

- Reads the output-image region of data memory after the CPU finishes a frame and streams each pixel out as an 8-bit valid/ready stream.
- This is the read side of the CPU's output-image writes at addresses >= 262144.
- Sits beside DataMemoryManager on a read port and feeds a UART/VGA/host sink.
- Reads are pipelined with a fixed memory latency; a 2-entry buffer absorbs sink backpressure.

---
 rtl/image_out_streamer.sv | 164 ++++++++++++++++
 tb/tb_image_out_streamer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_out_streamer.sv
// image_out_streamer: reads the output-image region of data memory after a
// frame and streams one byte per pixel on a valid/ready interface.
//
// Handshake: pix_valid_o/pix_data_o/pix_last_o come straight from the head of
// a 2-entry register FIFO. A transfer happens on a rising edge where
// pix_valid_o & pix_ready_i. Once valid is raised it stays high, with data and
// last stable, until that transfer.
module image_out_streamer #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BASE_ADDR  = 262144,
  parameter int unsigned NUM_PIXELS = 65536
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_rd_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [7:0]        pix_data_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              pix_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [16:0]       count_o,
  output logic [1:0]        state_o
);

  localparam int unsigned CNT_W = 17;
  localparam logic [CNT_W-1:0] NUM_PIX_C  = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              out_q, out_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [7:0]        buf_data_q [2];
  logic              buf_last_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        fill_q, fill_d;

  logic              start_ok;
  logic              push;
  logic              pop;
  logic [1:0]        occ;
  logic              credit_ok;
  logic              rd_strobe;
  logic              rd_is_last;
  logic [ADDR_W-1:0] rd_addr;
  logic              unused_data;

  // Only the low byte of a memory word is a pixel.
  assign unused_data = ^mem_data_i[DATA_W-1:8];

  assign start_ok = (state_q == S_IDLE) && start_i;
  assign push     = out_q;
  assign pop      = pix_valid_o && pix_ready_i;

  // Credit counts the slot freed by a pop in this same cycle, so a steady
  // ready sink gets one pixel per cycle; the cost is a combinational path
  // from pix_ready_i to mem_rd_o. Buffered + outstanding never exceeds 2.
  assign occ        = fill_q - {1'b0, pop} + {1'b0, out_q};
  assign credit_ok  = (occ < 2'd2);
  assign rd_strobe  = (state_q == S_READ) && credit_ok && (rd_idx_q < NUM_PIX_C);
  assign rd_is_last = (rd_idx_q == LAST_IDX_C);
  assign rd_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx_q);

  // Outputs decoded from registered state; address holds between strobes.
  assign mem_rd_o      = rd_strobe;
  assign mem_address_o = rd_strobe ? rd_addr : addr_q;
  assign pix_valid_o   = (fill_q != 2'd0);
  assign pix_data_o    = buf_data_q[rd_ptr_q];
  assign pix_last_o    = pix_valid_o && buf_last_q[rd_ptr_q];
  assign busy_o        = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o        = (state_q == S_DONE);
  assign count_o       = count_q;
  assign state_o       = state_q;

  // Frame sequencing: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_READ;
      S_READ:  if (rd_strobe && rd_is_last) state_d = S_DRAIN;
      S_DRAIN: if ((fill_q == 2'd0) && !out_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame sequencing: state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Read-side and counter next values.
  always_comb begin
    rd_idx_d   = rd_idx_q;
    addr_d     = addr_q;
    out_d      = rd_strobe;
    out_last_d = rd_strobe && rd_is_last;
    count_d    = count_q;
    fill_d     = fill_q + {1'b0, push} - {1'b0, pop};
    if (start_ok) begin
      rd_idx_d = '0;
      count_d  = '0;
    end else begin
      if (rd_strobe) rd_idx_d = rd_idx_q + 1'b1;
      if (pop && (count_q != NUM_PIX_C)) count_d = count_q + 1'b1;
    end
    if (rd_strobe) addr_d = rd_addr;
  end

  // Read index, held address, outstanding-read flag and transfer count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_idx_q   <= '0;
      addr_q     <= '0;
      out_q      <= 1'b0;
      out_last_q <= 1'b0;
      count_q    <= '0;
    end else begin
      rd_idx_q   <= rd_idx_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      out_last_q <= out_last_d;
      count_q    <= count_d;
    end
  end

  // Two-entry pixel FIFO: push the returning read, pop on transfer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= 8'd0;
        buf_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= mem_data_i[7:0];
        buf_last_q[wr_ptr_q] <= out_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fill_q <= fill_d;
    end
  end

endmodule

// File: tb/tb_image_out_streamer.sv
module tb_image_out_streamer;

  localparam int BASE = 262144;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] sel = 2'd0;
  int         mem_mode = 0;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  logic        start_v [3];
  logic        rd_v    [3];
  logic [31:0] addr_v  [3];
  logic [31:0] mdata_v [3];
  logic [7:0]  data_v  [3];
  logic        valid_v [3];
  logic        last_v  [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [16:0] cnt_v   [3];
  logic [1:0]  st_v    [3];

  logic        o_rd, o_valid, o_last, o_busy, o_done;
  logic [31:0] o_addr;
  logic [7:0]  o_data;
  logic [16:0] o_cnt;
  logic [1:0]  o_st;

  // clock / reset
  always #5 CLK = ~CLK;

  assign start_v[0] = start && (sel == 2'd0);
  assign start_v[1] = start && (sel == 2'd1);
  assign start_v[2] = start && (sel == 2'd2);

  image_out_streamer #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(262144), .NUM_PIXELS(4)) dut_a (
    .CLK(CLK), .RST(RST), .start_i(start_v[0]),
    .mem_address_o(addr_v[0]), .mem_rd_o(rd_v[0]), .mem_data_i(mdata_v[0]),
    .pix_data_o(data_v[0]), .pix_valid_o(valid_v[0]), .pix_ready_i(ready),
    .pix_last_o(last_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
    .count_o(cnt_v[0]), .state_o(st_v[0]));

  image_out_streamer #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(262144), .NUM_PIXELS(64)) dut_b (
    .CLK(CLK), .RST(RST), .start_i(start_v[1]),
    .mem_address_o(addr_v[1]), .mem_rd_o(rd_v[1]), .mem_data_i(mdata_v[1]),
    .pix_data_o(data_v[1]), .pix_valid_o(valid_v[1]), .pix_ready_i(ready),
    .pix_last_o(last_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]),
    .count_o(cnt_v[1]), .state_o(st_v[1]));

  image_out_streamer #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(262144), .NUM_PIXELS(1)) dut_c (
    .CLK(CLK), .RST(RST), .start_i(start_v[2]),
    .mem_address_o(addr_v[2]), .mem_rd_o(rd_v[2]), .mem_data_i(mdata_v[2]),
    .pix_data_o(data_v[2]), .pix_valid_o(valid_v[2]), .pix_ready_i(ready),
    .pix_last_o(last_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]),
    .count_o(cnt_v[2]), .state_o(st_v[2]));

  // memory contents: upper bytes are junk so only [7:0] may reach the pixel
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] i;
    i = 8'(a - 32'(BASE));
    return {8'hC3, a[15:0], (mem_mode != 0) ? (i ^ 8'hA5) : (8'h10 + i)};
  endfunction

  // one-cycle read latency memory model
  always @(posedge CLK) begin
    for (int k = 0; k < 3; k++)
      if (rd_v[k]) mdata_v[k] <= mem_word(addr_v[k]);
  end

  // observe the selected DUT
  always_comb begin
    o_rd = 1'b0; o_addr = '0; o_data = '0; o_valid = 1'b0; o_last = 1'b0;
    o_busy = 1'b0; o_done = 1'b0; o_cnt = '0; o_st = '0;
    for (int k = 0; k < 3; k++) begin
      if (sel == 2'(k)) begin
        o_rd = rd_v[k]; o_addr = addr_v[k]; o_data = data_v[k]; o_valid = valid_v[k];
        o_last = last_v[k]; o_busy = busy_v[k]; o_done = done_v[k]; o_cnt = cnt_v[k];
        o_st = st_v[k];
      end
    end
  end

  // driver: advance to 2 time units after the next rising edge
  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  // driver: pulse start for one cycle; returns in cycle 0 (first READ cycle)
  task automatic pulse_start();
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      v = {o_rd, o_addr, o_valid, o_data, o_last, o_busy, o_done, o_cnt, o_st};
      checks++;
      if (v !== 64'd0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: got %h expected 0", k, v);
      end
    end
    next_cycle();
    RST = 1'b1;
  endtask

  task automatic test_full_frame();
    logic [7:0] exp_data;
    logic exp_rd, exp_valid;
    sel = 2'd0; mem_mode = 0; ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_rd = (c <= 3);
      checks++;
      if (o_rd !== exp_rd || (exp_rd && o_addr !== 32'(BASE + c))) begin
        failures++;
        $display("FAIL full_read c=%0d: got rd=%b addr=%0d expected rd=%b addr=%0d",
                 c, o_rd, o_addr, exp_rd, BASE + c);
      end
      exp_valid = (c >= 2) && (c <= 5);
      exp_data  = 8'h10 + 8'(c - 2);
      checks++;
      if (o_valid !== exp_valid || (exp_valid && o_data !== exp_data) || o_last !== (c == 5)) begin
        failures++;
        $display("FAIL full_pixel c=%0d: got v=%b d=%h l=%b expected v=%b d=%h l=%b",
                 c, o_valid, o_data, o_last, exp_valid, exp_data, (c == 5));
      end
      checks++;
      if (o_done !== (c == 7) || o_busy !== (c <= 6)) begin
        failures++;
        $display("FAIL full_status c=%0d: got done=%b busy=%b expected done=%b busy=%b",
                 c, o_done, o_busy, (c == 7), (c <= 6));
      end
      next_cycle();
    end
    #1;
    checks++;
    if (o_cnt !== 17'd4) begin
      failures++;
      $display("FAIL full_count: got %0d expected 4", o_cnt);
    end
  endtask

  task automatic test_backpressure();
    int nrd, nxfer, nlast, ndone, stall_rd;
    logic [7:0] e;
    logic e_last;
    sel = 2'd0; mem_mode = 0; ready = 1'b1;
    nrd = 0; nxfer = 0; nlast = 0; ndone = 0; stall_rd = 0;
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13};
    pulse_start();
    for (int c = 0; c < 40; c++) begin
      ready = (c < 2) || (c > 6);
      #1;
      if (c >= 2 && c <= 6) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h10 || o_last !== 1'b0) begin
          failures++;
          $display("FAIL bp_hold c=%0d: got v=%b d=%h l=%b expected v=1 d=10 l=0",
                   c, o_valid, o_data, o_last);
        end
      end
      if (o_valid && ready) begin
        nxfer++;
        if (o_last) nlast++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra: got pixel %h expected none", o_data);
        end else begin
          e = exp_q.pop_front();
          e_last = (exp_q.size() == 0);
          if (o_data !== e || o_last !== e_last) begin
            failures++;
            $display("FAIL bp_pixel: got d=%h l=%b expected d=%h l=%b", o_data, o_last, e, e_last);
          end
        end
      end
      if (o_rd) begin
        if (c <= 6) stall_rd++;
        checks++;
        if (o_addr !== 32'(BASE + nrd)) begin
          failures++;
          $display("FAIL bp_addr: got %0d expected %0d", o_addr, BASE + nrd);
        end
        nrd++;
      end
      if (o_done) begin
        ndone++;
        break;
      end
      next_cycle();
    end
    checks++;
    if (stall_rd > 2) begin
      failures++;
      $display("FAIL bp_stall_reads: got %0d expected at most 2", stall_rd);
    end
    checks++;
    if (nrd != 4 || nxfer != 4 || nlast != 1 || ndone != 1 || o_cnt !== 17'd4) begin
      failures++;
      $display("FAIL bp_totals: got rd=%0d xfer=%0d last=%0d done=%0d cnt=%0d expected 4 4 1 1 4",
               nrd, nxfer, nlast, ndone, o_cnt);
    end
  endtask

  task automatic test_random_ready();
    int nrd, nxfer, nlast, ndone;
    logic prev_valid, prev_ready, prev_last;
    logic [7:0] prev_data, e;
    logic e_last;
    sel = 2'd1; mem_mode = 1; ready = 1'b0;
    nrd = 0; nxfer = 0; nlast = 0; ndone = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(i) ^ 8'hA5);
    pulse_start();
    for (int c = 0; c < 2000; c++) begin
      ready = ($urandom_range(0, 1) == 1);
      #1;
      if (prev_valid && !prev_ready) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== prev_data || o_last !== prev_last) begin
          failures++;
          $display("FAIL rr_stable c=%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   c, o_valid, o_data, o_last, prev_data, prev_last);
        end
      end
      if (o_valid && ready) begin
        nxfer++;
        if (o_last) nlast++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rr_extra: got pixel %h expected none", o_data);
        end else begin
          e = exp_q.pop_front();
          e_last = (exp_q.size() == 0);
          if (o_data !== e || o_last !== e_last) begin
            failures++;
            $display("FAIL rr_pixel n=%0d: got d=%h l=%b expected d=%h l=%b",
                     nxfer - 1, o_data, o_last, e, e_last);
          end
        end
      end
      if (o_rd) begin
        nrd++;
        checks++;
        if (o_addr !== 32'(BASE + nrd - 1) || (nrd - nxfer) > 2) begin
          failures++;
          $display("FAIL rr_read: got addr=%0d ahead=%0d expected addr=%0d ahead<=2",
                   o_addr, nrd - nxfer, BASE + nrd - 1);
        end
      end
      prev_valid = o_valid; prev_ready = ready; prev_data = o_data; prev_last = o_last;
      if (o_done) begin
        ndone++;
        break;
      end
      next_cycle();
    end
    checks++;
    if (nrd != 64 || nxfer != 64 || nlast != 1 || ndone != 1 || o_cnt !== 17'd64) begin
      failures++;
      $display("FAIL rr_totals: got rd=%0d xfer=%0d last=%0d done=%0d cnt=%0d expected 64 64 1 1 64",
               nrd, nxfer, nlast, ndone, o_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    int nrd, nxfer, ndone;
    logic [7:0] e;
    sel = 2'd0; mem_mode = 0; ready = 1'b1;
    nrd = 0; nxfer = 0; ndone = 0;
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13};
    pulse_start();
    for (int c = 0; c < 20; c++) begin
      start = (c == 3);
      #1;
      if (o_rd) nrd++;
      if (o_valid && ready) begin
        nxfer++;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (o_data !== e) begin
          failures++;
          $display("FAIL sb_pixel: got %h expected %h", o_data, e);
        end
      end
      if (o_done) begin
        ndone++;
        start = 1'b1;
      end
      next_cycle();
    end
    start = 1'b0;
    #1;
    checks++;
    if (nrd != 4 || nxfer != 4 || ndone != 1) begin
      failures++;
      $display("FAIL sb_totals: got rd=%0d xfer=%0d done=%0d expected 4 4 1", nrd, nxfer, ndone);
    end
    checks++;
    if (o_busy !== 1'b0 || o_cnt !== 17'd4) begin
      failures++;
      $display("FAIL sb_idle_hold: got busy=%b cnt=%0d expected busy=0 cnt=4", o_busy, o_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nxfer, ndone;
    logic [63:0] v;
    logic [7:0] e;
    sel = 2'd0; mem_mode = 0; ready = 1'b1;
    nxfer = 0;
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (o_valid && ready) nxfer++;
      next_cycle();
      if (nxfer == 2) break;
    end
    #1;
    RST = 1'b0;
    #1;
    v = {o_rd, o_addr, o_valid, o_data, o_last, o_busy, o_done, o_cnt, o_st};
    checks++;
    if (nxfer != 2 || v !== 64'd0) begin
      failures++;
      $display("FAIL rm_async_reset: got xfer=%0d outputs=%h expected xfer=2 outputs=0", nxfer, v);
    end
    next_cycle();
    RST = 1'b1;
    pulse_start();
    #1;
    checks++;
    if (o_rd !== 1'b1 || o_addr !== 32'(BASE) || o_cnt !== 17'd0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL rm_restart: got rd=%b addr=%0d cnt=%0d busy=%b expected rd=1 addr=%0d cnt=0 busy=1",
               o_rd, o_addr, o_cnt, o_busy, BASE);
    end
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13};
    nxfer = 0; ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) #1;
      if (o_valid && ready) begin
        nxfer++;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (o_data !== e) begin
          failures++;
          $display("FAIL rm_pixel: got %h expected %h", o_data, e);
        end
      end
      if (o_done) begin
        ndone++;
        break;
      end
      next_cycle();
    end
    checks++;
    if (nxfer != 4 || ndone != 1 || o_cnt !== 17'd4) begin
      failures++;
      $display("FAIL rm_totals: got xfer=%0d done=%0d cnt=%0d expected 4 1 4", nxfer, ndone, o_cnt);
    end
  endtask

  task automatic test_single_pixel();
    sel = 2'd2; mem_mode = 0; ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 7; c++) begin
      #1;
      checks++;
      if (o_rd !== (c == 0) || (c == 0 && o_addr !== 32'(BASE))) begin
        failures++;
        $display("FAIL one_read c=%0d: got rd=%b addr=%0d expected rd=%b addr=%0d",
                 c, o_rd, o_addr, (c == 0), BASE);
      end
      checks++;
      if (o_valid !== (c == 2) || o_last !== (c == 2) || (c == 2 && o_data !== 8'h10)) begin
        failures++;
        $display("FAIL one_pixel c=%0d: got v=%b l=%b d=%h expected v=%b l=%b d=10",
                 c, o_valid, o_last, o_data, (c == 2), (c == 2));
      end
      checks++;
      if (o_done !== (c == 4)) begin
        failures++;
        $display("FAIL one_done c=%0d: got %b expected %b", c, o_done, (c == 4));
      end
      next_cycle();
    end
    #1;
    checks++;
    if (o_cnt !== 17'd1) begin
      failures++;
      $display("FAIL one_count: got %0d expected 1", o_cnt);
    end
  endtask

  // sequence of scenarios and final report
  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_random_ready();
    test_start_while_busy();
    test_reset_mid_frame();
    test_single_pixel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
